// File: rtl/state_ram_pkg.sv
// state_ram_pkg
//   Shared constants for the per-state 256-bit storage block: geometry,
//   read/write encoding of the rdwr strobe, and the reset image of each word.
package state_ram_pkg;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  // rdwr encoding
  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  // Reset contents of word k: the state code repeated in every byte lane.
  function automatic logic [DATA_W-1:0] init_word(input logic [7:0] k);
    return {(DATA_W / 8){k}};
  endfunction

endpackage

// File: rtl/state_ram_array.sv
// state_ram_array
//   DEPTH x DATA_W register array with asynchronous reset initialisation.
//   A register array is used instead of a RAM macro because every word must
//   come out of reset holding its init_word() image.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset (loads init_word(k) into word k)
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address (combinational read)
//   o_rdata  read data for i_raddr, pre-write contents
module state_ram_array
  import state_ram_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_mem[k] <= init_word(8'(k));
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/state_ram_top.sv
// state_ram_top
//   Single-port 8 x 256-bit per-state storage, addressed by the state code.
//   Every edge is either a read or a write; q is registered (one-cycle
//   latency) and a write is reflected on q in the same edge (write-through).
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset (q cleared, memory re-initialised)
//   rdwr   0 = read, 1 = write
//   st     word address (state code 0..7)
//   PD     write data
//   q      registered read / write-through data
module state_ram_top
  import state_ram_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              rdwr,
  input  logic [ADDR_W-1:0] st,
  input  logic [DATA_W-1:0] PD,
  output logic [DATA_W-1:0] q
);

  logic              w_we;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] r_q;

  // Only a definite 1 writes, so an unknown rdwr in simulation cannot
  // corrupt the array; synthesises to plain rdwr.
  assign w_we = (rdwr === WR);

  state_ram_array u_array (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_we    (w_we),
    .i_waddr (st),
    .i_wdata (PD),
    .i_raddr (st),
    .o_rdata (w_rdata)
  );

  // The array read is pre-write, so a write must bypass it to give
  // write-first behaviour on q.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_q <= '0;
    end else begin
      r_q <= w_we ? PD : w_rdata;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_state_ram_top.sv
module tb_state_ram_top;
  import state_ram_pkg::*;

  logic              CLK;
  logic              RST_N;
  logic              rdwr;
  logic [ADDR_W-1:0] st;
  logic [DATA_W-1:0] PD;
  logic [DATA_W-1:0] q;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] m_mem [DEPTH];

  localparam logic [DATA_W-1:0] PAT  = {8{32'hDEADBEEF}};
  localparam logic [DATA_W-1:0] ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};

  state_ram_top dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .rdwr  (rdwr),
    .st    (st),
    .PD    (PD),
    .q     (q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask

  // Reference memory image after reset: byte k repeated.
  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [7:0] b;
      b = 8'(i);
      m_mem[i] = {32{b}};
    end
  endtask

  // One access: drive at the falling edge, predict, compare 1 after the rising edge.
  task automatic cycle(input logic rw, input int unsigned addr,
                       input logic [DATA_W-1:0] data, input string tag);
    exp_t e;
    @(negedge CLK);
    rdwr = rw;
    st   = ADDR_W'(addr);
    PD   = data;
    e.tag = tag;
    if (rw === 1'b1) begin
      m_mem[addr] = data;
      e.val = data;
    end else begin
      e.val = m_mem[addr];
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", q, ZERO);
    end else begin
      e = sb.pop_front();
      chk(e.tag, q, e.val);
    end
  endtask

  // Reset asserted between edges; q must clear without a clock edge.
  task automatic async_reset(input string tag);
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk(tag, q, ZERO);
    model_reset();
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_N = 1'b1;
    rdwr  = RD;
    st    = '0;
    PD    = '0;

    // Make q non-zero first so the reset clear is observable.
    cycle(WR, 1, PAT, "pre_rst_wr");
    async_reset("rst_q_immediate");

    for (int unsigned k = 0; k < DEPTH; k++) cycle(RD, k, ZERO, "rst_image_rd");

    for (int unsigned k = 0; k < 6; k++)
      for (int r = 0; r < 5; r++) cycle(RD, k, ZERO, "read_sweep");

    for (int r = 0; r < 5; r++) cycle(WR, 6, ZERO, "wr6_zero");
    for (int r = 0; r < 5; r++) cycle(WR, 7, PAT, "wr7_pat");
    cycle(RD, 6, ZERO, "rd6");
    cycle(RD, 7, ZERO, "rd7");
    cycle(RD, 0, ZERO, "rd0_unchanged");

    cycle(WR, 3, ONES, "wf_wr3");
    cycle(RD, 3, ZERO, "wf_rd3");
    cycle(RD, 2, ZERO, "wf_rd2");

    cycle(WR, 7, PAT, "pre_rst2_wr7");
    async_reset("rst_mid_op_q");
    cycle(RD, 7, ZERO, "rd7_restored");
    cycle(RD, 3, ZERO, "rd3_restored");

    cycle(1'bx, 4, ONES, "x_rdwr");
    cycle(RD, 4, ZERO, "x_rd4");
    cycle(RD, 5, ZERO, "x_rd5");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
